// File: rtl/grey_counter_n.sv
// N-digit decimal counter with each digit held in a 5-bit single-step code.
// It supports up/down counting, parallel load, a wrap pulse and a sticky illegal-code flag.
// Optional macro GREY_SAT_EN makes the counter saturate at all-9 or all-0 instead of wrapping.
module grey_counter_n #(
    parameter int unsigned  DIGITS = 4,
    localparam int unsigned W      = 5 * DIGITS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_up,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_wrap,
    output logic         o_err
);

    function automatic logic is_legal(input logic [4:0] c);
        case (c)
            5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
            5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000: is_legal = 1'b1;
            default:                                          is_legal = 1'b0;
        endcase
    endfunction

    // Illegal codes decode to 0 so stray patterns can never propagate.
    function automatic logic [3:0] dec(input logic [4:0] c);
        case (c)
            5'b00001: dec = 4'd1;
            5'b00011: dec = 4'd2;
            5'b00010: dec = 4'd3;
            5'b00110: dec = 4'd4;
            5'b00100: dec = 4'd5;
            5'b01100: dec = 4'd6;
            5'b01000: dec = 4'd7;
            5'b11000: dec = 4'd8;
            5'b10000: dec = 4'd9;
            default:  dec = 4'd0;
        endcase
    endfunction

    function automatic logic [4:0] enc(input logic [3:0] v);
        case (v)
            4'd1:    enc = 5'b00001;
            4'd2:    enc = 5'b00011;
            4'd3:    enc = 5'b00010;
            4'd4:    enc = 5'b00110;
            4'd5:    enc = 5'b00100;
            4'd6:    enc = 5'b01100;
            4'd7:    enc = 5'b01000;
            4'd8:    enc = 5'b11000;
            4'd9:    enc = 5'b10000;
            default: enc = 5'b00000;
        endcase
    endfunction

    logic [W-1:0]    count_q, count_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;
    logic [W-1:0]    step_code;
    logic [W-1:0]    load_clean;
    logic            load_bad;
    logic [DIGITS:0] carry;
    logic [3:0]      cur_val;
    logic [3:0]      nxt_val;

    // Ripple carry/borrow: digit k steps iff every lower digit sits at its turning value.
    always_comb begin
        carry      = '0;
        carry[0]   = 1'b1;
        step_code  = '0;
        load_clean = '0;
        load_bad   = 1'b0;
        cur_val    = 4'd0;
        nxt_val    = 4'd0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            cur_val = dec(count_q[5*k +: 5]);
            nxt_val = cur_val;
            if (carry[k]) begin
                if (i_up) nxt_val = (cur_val == 4'd9) ? 4'd0 : 4'(cur_val + 4'd1);
                else      nxt_val = (cur_val == 4'd0) ? 4'd9 : 4'(cur_val - 4'd1);
            end
            carry[k+1] = carry[k] & (i_up ? (cur_val == 4'd9) : (cur_val == 4'd0));
            step_code[5*k +: 5] = enc(nxt_val);

            if (is_legal(i_load_val[5*k +: 5])) begin
                load_clean[5*k +: 5] = i_load_val[5*k +: 5];
            end else begin
                load_bad = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (i_load) begin
            count_d = load_clean;
            err_d   = err_q | load_bad;
        end else if (i_en) begin
`ifdef GREY_SAT_EN
            // Saturated: hold the value and flag the refused step.
            if (carry[DIGITS]) begin
                count_d = count_q;
                wrap_d  = 1'b1;
            end else begin
                count_d = step_code;
            end
`else
            count_d = step_code;
            wrap_d  = carry[DIGITS];
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign o_count = count_q;
    assign o_wrap  = wrap_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_grey_counter_n.sv
// Scoreboard bench for grey_counter_n: 4-digit and 3-digit instances are checked against a decimal model.
module tb_grey_counter_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [19:0] lv = '0;
    logic [19:0] cnt4;
    logic [14:0] cnt3;
    logic        wrap4, wrap3, err4, err3;

    always #5 clk = ~clk;

    grey_counter_n #(.DIGITS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(lv), .o_count(cnt4), .o_wrap(wrap4), .o_err(err4)
    );

    grey_counter_n #(.DIGITS(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(lv[14:0]), .o_count(cnt3), .o_wrap(wrap3), .o_err(err3)
    );

    typedef struct {
        logic [19:0] c4;
        logic [14:0] c3;
        logic        w4, w3, e4, e3;
        bit          step;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    logic [4:0] lut [10] = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06,
                             5'h04, 5'h0C, 5'h08, 5'h18, 5'h10};

    int m_val [2];
    bit m_err [2];
    bit m_wrap [2];
    int nd_of [2] = '{4, 3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    endtask

    function automatic logic [19:0] encode(input int v, input int nd);
        logic [19:0] r = '0;
        int          x = v;
        for (int k = 0; k < nd; k++) begin
            r[5*k +: 5] = lut[x % 10];
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int decode_load(input logic [19:0] v, input int nd, output bit bad);
        int val = 0;
        int p = 1;
        bad = 0;
        for (int k = 0; k < nd; k++) begin
            int d = 0;
            bit found = 0;
            for (int j = 0; j < 10; j++) begin
                if (lut[j] == v[5*k +: 5]) begin
                    d = j;
                    found = 1;
                end
            end
            if (!found) bad = 1;
            val += d * p;
            p *= 10;
        end
        return val;
    endfunction

    function automatic int max_flip(input logic [19:0] a, input logic [19:0] b, input int nd);
        int mx = 0;
        for (int k = 0; k < nd; k++) begin
            logic [4:0] x = a[5*k +: 5] ^ b[5*k +: 5];
            if ($countones(x) > mx) mx = $countones(x);
        end
        return mx;
    endfunction

    task automatic model_step(input int i, input bit r, input bit ld, input bit e, input bit u,
                              input logic [19:0] v);
        int modv = 1;
        bit bad;
        for (int k = 0; k < nd_of[i]; k++) modv *= 10;
        m_wrap[i] = 0;
        if (r) begin
            m_val[i] = 0;
            m_err[i] = 0;
        end else if (ld) begin
            m_val[i] = decode_load(v, nd_of[i], bad);
            if (bad) m_err[i] = 1;
        end else if (e) begin
            if (u && m_val[i] == modv - 1) begin
                m_wrap[i] = 1;
`ifndef GREY_SAT_EN
                m_val[i] = 0;
`endif
            end else if (!u && m_val[i] == 0) begin
                m_wrap[i] = 1;
`ifndef GREY_SAT_EN
                m_val[i] = modv - 1;
`endif
            end else begin
                m_val[i] = u ? m_val[i] + 1 : m_val[i] - 1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit ld, input bit e, input bit u, input logic [19:0] v);
        exp_t        x;
        logic [19:0] t;
        @(negedge clk);
        rst = r; load = ld; en = e; up = u; lv = v;
        for (int i = 0; i < 2; i++) model_step(i, r, ld, e, u, v);
        x.c4 = encode(m_val[0], 4);
        t = encode(m_val[1], 3);
        x.c3 = t[14:0];
        x.w4 = m_wrap[0];
        x.w3 = m_wrap[1];
        x.e4 = m_err[0];
        x.e3 = m_err[1];
        x.step = !r && !ld;
        sb.push_back(x);
    endtask

    // Monitor: the DUT presents a new count every cycle; compare just after the edge.
    exp_t        ex;
    logic [19:0] prev4 = '0;
    logic [14:0] prev3 = '0;
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            ex = sb.pop_front();
            chk("count4", 32'(cnt4), 32'(ex.c4));
            chk("count3", 32'(cnt3), 32'(ex.c3));
            chk("wrap4", 32'(wrap4), 32'(ex.w4));
            chk("wrap3", 32'(wrap3), 32'(ex.w3));
            chk("err4", 32'(err4), 32'(ex.e4));
            chk("err3", 32'(err3), 32'(ex.e3));
            if (ex.step) begin
                chk("multi_bit_step4", 32'(max_flip(prev4, cnt4, 4) > 1), 32'd0);
                chk("multi_bit_step3", 32'(max_flip({5'b0, prev3}, {5'b0, cnt3}, 3) > 1), 32'd0);
            end
            prev4 = cnt4;
            prev3 = cnt3;
        end
    end

    function automatic logic [19:0] rand_lv(input bit bias_up);
        logic [19:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            int sel = $urandom_range(0, 19);
            if (sel == 0)      r[5*k +: 5] = 5'($urandom);
            else if (sel < 10) r[5*k +: 5] = bias_up ? lut[9] : lut[0];
            else               r[5*k +: 5] = lut[$urandom_range(0, 9)];
        end
        return r;
    endfunction

    bit dir = 1;

    initial begin
        cycle(1, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, '0);

        cycle(0, 1, 0, 0, 20'h00610);
        cycle(0, 0, 1, 1, '0);
        cycle(0, 0, 1, 0, '0);

        cycle(0, 1, 0, 0, 20'h84210);
        cycle(0, 0, 1, 1, '0);
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, '0);

        cycle(0, 1, 0, 0, 20'h00005);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1, '0);
        cycle(1, 0, 0, 0, '0);

        cycle(1, 1, 1, 1, 20'h84210);
        cycle(0, 1, 1, 1, 20'h84210);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, '0);

        for (int i = 0; i < 5000; i++) begin
            int r = $urandom_range(0, 999);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            cycle(r < 2, (r >= 2) && (r < 30), $urandom_range(0, 9) != 0, dir, rand_lv(dir));
        end

        cycle(0, 0, 0, 0, '0);
        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
